// File: rtl/blood_anim_reader.sv
// Blood-splatter sprite reader: plays a FRAMES-long animation anchored at a hit point
// and streams the selected 64x64 frame ROM onto the pixel pipeline with a fixed 2-clk latency.
module blood_anim_reader #(
    parameter int          FRAMES          = 12,
    parameter int          TICKS_PER_FRAME = 4,
    parameter logic [11:0] TRANSPARENT     = 12'h000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        video_on,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        frame_tick,
    input  logic        hit,
    input  logic [9:0]  hit_x,
    input  logic [9:0]  hit_y,
    output logic [5:0]  rom_row,
    output logic [5:0]  rom_col,
    output logic [3:0]  rom_sel,
    input  logic [11:0] rom_data,
    output logic [11:0] rgb_out,
    output logic        blood_on,
    output logic        busy
);

    typedef enum logic {IDLE, PLAY} state_t;

    localparam logic [3:0] FRAME_LAST = 4'(FRAMES - 1);
    localparam logic [7:0] TICK_LAST  = 8'(TICKS_PER_FRAME - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_frame;
    logic [3:0]  w_frame_next;
    logic [7:0]  r_tick_cnt;
    logic [7:0]  w_tick_cnt_next;
    logic [9:0]  r_ax;
    logic [9:0]  w_ax_next;
    logic [9:0]  r_ay;
    logic [9:0]  w_ay_next;

    logic        r_in_box_d1;
    logic [11:0] r_rgb_out;
    logic        r_blood_on;

    logic [10:0] w_dx;
    logic [10:0] w_dy;
    logic        w_x_ge;
    logic        w_y_ge;
    logic        w_in_box;
    logic        w_opaque;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_frame    <= 4'd0;
            r_tick_cnt <= 8'd0;
            r_ax       <= 10'd0;
            r_ay       <= 10'd0;
        end else begin
            r_state    <= w_state_next;
            r_frame    <= w_frame_next;
            r_tick_cnt <= w_tick_cnt_next;
            r_ax       <= w_ax_next;
            r_ay       <= w_ay_next;
        end
    end

    // A hit always (re)starts from frame 0 and wins over a coincident frame_tick.
    always_comb begin
        w_state_next    = r_state;
        w_frame_next    = r_frame;
        w_tick_cnt_next = r_tick_cnt;
        w_ax_next       = r_ax;
        w_ay_next       = r_ay;
        if (hit) begin
            w_state_next    = PLAY;
            w_frame_next    = 4'd0;
            w_tick_cnt_next = 8'd0;
            w_ax_next       = hit_x;
            w_ay_next       = hit_y;
        end else if (r_state == PLAY && frame_tick) begin
            if (r_tick_cnt == TICK_LAST) begin
                w_tick_cnt_next = 8'd0;
                if (r_frame == FRAME_LAST) begin
                    w_state_next = IDLE;
                    w_frame_next = 4'd0;
                end else begin
                    w_frame_next = r_frame + 4'd1;
                end
            end else begin
                w_tick_cnt_next = r_tick_cnt + 8'd1;
            end
        end
    end

    assign busy    = (r_state == PLAY);
    assign rom_sel = busy ? r_frame : 4'd0;

    // 11-bit offsets plus separate >= checks keep an anchor near 1023 from wrapping to 0.
    assign w_dx     = {1'b0, x} - {1'b0, r_ax};
    assign w_dy     = {1'b0, y} - {1'b0, r_ay};
    assign w_x_ge   = (x >= r_ax);
    assign w_y_ge   = (y >= r_ay);
    assign rom_col  = w_dx[5:0];
    assign rom_row  = w_dy[5:0];
    assign w_in_box = busy & video_on & w_x_ge & (w_dx < 11'd64) & w_y_ge & (w_dy < 11'd64);
    assign w_opaque = r_in_box_d1 & (rom_data != TRANSPARENT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_box_d1 <= 1'b0;
            r_rgb_out   <= 12'h000;
            r_blood_on  <= 1'b0;
        end else begin
            r_in_box_d1 <= w_in_box;
            r_blood_on  <= w_opaque;
            r_rgb_out   <= w_opaque ? rom_data : 12'h000;
        end
    end

    assign rgb_out  = r_rgb_out;
    assign blood_on = r_blood_on;

endmodule

// File: tb/tb_blood_anim_reader.sv
// Bench for blood_anim_reader: directed scenarios followed by a randomized run
// checked against a tick-counting reference model and a model frame ROM.
module tb_blood_anim_reader;

    localparam int FRAMES = 12;
    localparam int TPF    = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        video_on = 1'b0;
    logic [9:0]  x = '0;
    logic [9:0]  y = '0;
    logic        frame_tick = 1'b0;
    logic        hit = 1'b0;
    logic [9:0]  hit_x = '0;
    logic [9:0]  hit_y = '0;
    logic [5:0]  rom_row;
    logic [5:0]  rom_col;
    logic [3:0]  rom_sel;
    logic [11:0] rom_data = '0;
    logic [11:0] rgb_out;
    logic        blood_on;
    logic        busy;

    logic        rom_force = 1'b0;
    logic [11:0] rom_force_val = '0;

    int n_checks = 0;
    int n_fail   = 0;

    blood_anim_reader #(.FRAMES(FRAMES), .TICKS_PER_FRAME(TPF), .TRANSPARENT(12'h000)) dut (
        .clk(clk), .reset(reset), .video_on(video_on), .x(x), .y(y),
        .frame_tick(frame_tick), .hit(hit), .hit_x(hit_x), .hit_y(hit_y),
        .rom_row(rom_row), .rom_col(rom_col), .rom_sel(rom_sel), .rom_data(rom_data),
        .rgb_out(rgb_out), .blood_on(blood_on), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] rom_fn(input logic [3:0] s, input logic [5:0] r, input logic [5:0] c);
        if (((r ^ c) & 6'd7) == 6'd0) return 12'h000;
        return {s, r[3:0], c[3:0]};
    endfunction

    // Frame ROM model: registered address, muxed by rom_sel.
    always @(posedge clk)
        rom_data <= rom_force ? rom_force_val : rom_fn(rom_sel, rom_row, rom_col);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        $display("check %s: observed %0h expected %0h", tag, obs, exp);
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_hit(input int hx, input int hy);
        hit = 1'b1; hit_x = 10'(hx); hit_y = 10'(hy);
        step();
        hit = 1'b0;
    endtask

    task automatic do_tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
    endtask

    // Present one visible pixel, check its ROM column, and wait out the 2-clk latency.
    task automatic pix(input int px, input int py, input int exp_col, input string tag);
        x = 10'(px); y = 10'(py); video_on = 1'b1;
        #1;
        if (exp_col >= 0) check({tag, "_col"}, 32'(rom_col), 32'(exp_col));
        step();
        video_on = 1'b0;
        step();
    endtask

    // Reference model state
    bit   m_busy;
    int   m_ticks;
    int   m_ax, m_ay;
    logic q_on[$];
    logic [11:0] q_rgb[$];

    initial begin
        // Reset
        reset = 1'b1;
        step(); step();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_sel", 32'(rom_sel), 32'd0);
        check("reset_blood", 32'(blood_on), 32'd0);
        check("reset_rgb", 32'(rgb_out), 32'd0);
        reset = 1'b0;
        step();

        // Basic hit and 2-clk pixel path
        do_hit(100, 50);
        check("hit_busy", 32'(busy), 32'd1);
        rom_force = 1'b1; rom_force_val = 12'hE00;
        x = 10'd110; y = 10'd60; video_on = 1'b1;
        #1;
        check("basic_row", 32'(rom_row), 32'd10);
        pix(110, 60, 10, "basic");
        check("basic_blood", 32'(blood_on), 32'd1);
        check("basic_rgb", 32'(rgb_out), 32'hE00);

        // Box edges and transparency
        pix(99, 60, -1, "left");
        check("left_blood", 32'(blood_on), 32'd0);
        pix(164, 60, -1, "right");
        check("right_blood", 32'(blood_on), 32'd0);
        pix(163, 113, 63, "corner");
        check("corner_blood", 32'(blood_on), 32'd1);
        pix(110, 49, -1, "above");
        check("above_blood", 32'(blood_on), 32'd0);
        rom_force_val = 12'h000;
        pix(110, 60, 10, "transp");
        check("transp_blood", 32'(blood_on), 32'd0);
        check("transp_rgb", 32'(rgb_out), 32'd0);

        // Anchor near the right edge clips without wrapping
        rom_force_val = 12'hE00;
        do_hit(1000, 50);
        pix(1023, 60, 23, "clip");
        check("clip_blood", 32'(blood_on), 32'd1);
        for (int i = 0; i < 40; i++) begin
            pix(i, 60, -1, "wrap");
            check("wrap_blood", 32'(blood_on), 32'd0);
        end

        // Full animation: 48 ticks
        do_hit(10, 10);
        for (int i = 0; i < FRAMES * TPF; i++) begin
            check("anim_sel", 32'(rom_sel), 32'(i / TPF));
            check("anim_busy", 32'(busy), 32'd1);
            do_tick();
        end
        check("anim_end_busy", 32'(busy), 32'd0);
        check("anim_end_sel", 32'(rom_sel), 32'd0);

        // Hit wins over a same-cycle frame_tick
        do_hit(10, 10);
        for (int i = 0; i < 5 * TPF; i++) do_tick();
        check("pri_sel5", 32'(rom_sel), 32'd5);
        hit = 1'b1; frame_tick = 1'b1; hit_x = 10'd200; hit_y = 10'd300;
        step();
        hit = 1'b0; frame_tick = 1'b0;
        check("pri_sel0", 32'(rom_sel), 32'd0);
        check("pri_busy", 32'(busy), 32'd1);
        for (int i = 0; i < TPF - 1; i++) do_tick();
        check("pri_tick_sel", 32'(rom_sel), 32'd0);
        do_tick();
        check("pri_next_sel", 32'(rom_sel), 32'd1);
        pix(205, 310, 5, "pri_anchor");
        check("pri_anchor_blood", 32'(blood_on), 32'd1);

        // Reset aborts playback
        do_hit(10, 10);
        for (int i = 0; i < 7 * TPF; i++) do_tick();
        check("abort_sel7", 32'(rom_sel), 32'd7);
        x = 10'd20; y = 10'd20; video_on = 1'b1;
        step(); step();
        check("abort_pre_blood", 32'(blood_on), 32'd1);
        reset = 1'b1;
        step();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_sel", 32'(rom_sel), 32'd0);
        check("abort_blood", 32'(blood_on), 32'd0);
        check("abort_rgb", 32'(rgb_out), 32'd0);

        // Randomized run against the reference model
        video_on = 1'b0; rom_force = 1'b0;
        step();
        reset = 1'b0;
        m_busy = 1'b0; m_ticks = 0; m_ax = 0; m_ay = 0;
        for (int k = 0; k < 900; k++) begin
            int xv, yv, exp_sel, exp_col, exp_row;
            bit exp_in;
            logic [11:0] exp_data;
            hit        = (k == 0) || ($urandom_range(0, 119) == 0);
            hit_x      = 10'($urandom_range(0, 1023));
            hit_y      = 10'($urandom_range(0, 1023));
            frame_tick = ($urandom_range(0, 3) == 0);
            video_on   = ($urandom_range(0, 7) != 0);
            xv = m_ax + int'($urandom_range(0, 90)) - 10;
            yv = m_ay + int'($urandom_range(0, 90)) - 10;
            if (xv < 0) xv = 0;
            if (xv > 1023) xv = 1023;
            if (yv < 0) yv = 0;
            if (yv > 1023) yv = 1023;
            x = 10'(xv); y = 10'(yv);
            #1;
            exp_sel = m_busy ? m_ticks / TPF : 0;
            exp_col = (xv - m_ax) & 63;
            exp_row = (yv - m_ay) & 63;
            exp_in  = m_busy && video_on && (xv >= m_ax) && (xv - m_ax < 64) && (yv >= m_ay) && (yv - m_ay < 64);
            exp_data = rom_fn(4'(exp_sel), 6'(exp_row), 6'(exp_col));
            check("rnd_busy", 32'(busy), 32'(m_busy));
            check("rnd_sel", 32'(rom_sel), 32'(exp_sel));
            check("rnd_col", 32'(rom_col), 32'(exp_col));
            check("rnd_row", 32'(rom_row), 32'(exp_row));
            q_on.push_back(exp_in && exp_data != 12'h000);
            q_rgb.push_back((exp_in && exp_data != 12'h000) ? exp_data : 12'h000);
            step();
            if (hit) begin
                m_busy = 1'b1; m_ticks = 0; m_ax = int'(hit_x); m_ay = int'(hit_y);
            end else if (m_busy && frame_tick) begin
                m_ticks++;
                if (m_ticks == FRAMES * TPF) begin
                    m_busy = 1'b0; m_ticks = 0;
                end
            end
            if (q_on.size() == 2) begin
                check("rnd_blood", 32'(blood_on), 32'(q_on[0]));
                check("rnd_rgb", 32'(rgb_out), 32'(q_rgb[0]));
                void'(q_on.pop_front());
                void'(q_rgb.pop_front());
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/blood_anim_reader.md
BLOOD_ANIM_READER -- requirements
Module: blood_anim_reader

Interface
REQ-001 The block SHALL have parameter FRAMES, default 12, number of blood-splatter frame ROMs (valid range 2..16).
REQ-002 The block SHALL have parameter TICKS_PER_FRAME, default 4, number of frame_tick pulses each animation frame is shown (valid range 1..255).
REQ-003 The block SHALL have parameter TRANSPARENT, default 12'h000, the ROM colour treated as see-through.
REQ-004 clk  input  1  system/pixel clock; all state on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 video_on  input  1  current pixel is in the visible area.
REQ-007 x  input  10  current pixel column.
REQ-008 y  input  10  current pixel row.
REQ-009 frame_tick  input  1  one-cycle pulse, once per video frame (start of vertical blank).
REQ-010 hit  input  1  one-cycle trigger that starts or restarts the animation.
REQ-011 hit_x  input  10  sprite top-left column, sampled with hit.
REQ-012 hit_y  input  10  sprite top-left row, sampled with hit.
REQ-013 rom_row  output  6  row address to the 64x64 frame ROMs.
REQ-014 rom_col  output  6  column address to the 64x64 frame ROMs.
REQ-015 rom_sel  output  4  index of the frame ROM whose color_data is muxed onto rom_data.
REQ-016 rom_data  input  12  12-bit colour from the selected ROM; valid one clk after rom_row/rom_col (ROM registers its address).
REQ-017 rgb_out  output  12  blood pixel colour.
REQ-018 blood_on  output  1  rgb_out is an opaque blood pixel this cycle.
REQ-019 busy  output  1  animation in progress.

Function
REQ-020 FSM states SHALL be IDLE and PLAY; busy = (state == PLAY).
REQ-021 IDLE + hit: latch hit_x/hit_y into anchor ax/ay, frame = 0, tick_cnt = 0, go to PLAY next cycle.
REQ-022 PLAY + hit: re-latch anchor, frame = 0, tick_cnt = 0, stay in PLAY; hit SHALL take priority over a same-cycle frame_tick.
REQ-023 PLAY + frame_tick (no hit), tick_cnt < TICKS_PER_FRAME-1: tick_cnt increments.
REQ-024 PLAY + frame_tick (no hit), tick_cnt == TICKS_PER_FRAME-1: tick_cnt = 0; if frame < FRAMES-1, frame increments; else go to IDLE with frame = 0.
REQ-025 Frame and anchor SHALL change only on hit or frame_tick, so no mid-frame tearing.
REQ-026 rom_sel SHALL equal frame in PLAY and 0 in IDLE.
REQ-027 dx = x - ax and dy = y - ay SHALL be computed at 11 bits unsigned with x >= ax and y >= ay checked separately; rom_col = dx[5:0], rom_row = dy[5:0], both combinational from x, y, and the anchor.
REQ-028 in_box = busy & video_on & (x >= ax) & (dx < 64) & (y >= ay) & (dy < 64); an anchor near 1023 SHALL clip with no wrap to column/row 0.
REQ-029 Stage 1: in_box SHALL be registered as in_box_d1, aligned with rom_data.
REQ-030 Stage 2: rgb_out and blood_on SHALL be registered; blood_on = in_box_d1 & (rom_data != TRANSPARENT); rgb_out = rom_data when blood_on, else 12'h000.
REQ-031 Total latency from x/y to rgb_out/blood_on SHALL be exactly 2 clk; the parent delays video sync by 2 to match.
REQ-032 The last pixels of a frame on the cycle the FSM goes to IDLE SHALL still drain through the pipeline; the pipeline SHALL not be flushed.

Reset
REQ-033 Reset SHALL have priority over hit and frame_tick.
REQ-034 On reset: state = IDLE, frame = 0, tick_cnt = 0, ax = ay = 0, in_box_d1 = 0, rgb_out = 12'h000, blood_on = 0, busy = 0, rom_sel = 0.
REQ-035 Reset during PLAY SHALL abort the animation; outputs SHALL be at reset values on the next cycle.

Verification
REQ-036 hit with hit_x=100, hit_y=50, then x=110, y=60, video_on=1, rom_data=12'hE00 one cycle later -> rom_col=10 and rom_row=10 same cycle; rgb_out=12'hE00 and blood_on=1 two cycles after x/y.
REQ-037 Same anchor, x=99 or x=164 -> blood_on=0; in-box pixel with rom_data=12'h000 -> blood_on=0, rgb_out=0.
REQ-038 Defaults, hit then 48 frame_tick pulses -> rom_sel steps 0..11 every 4 ticks; busy falls on the 48th tick; rom_sel=0.
REQ-039 hit and frame_tick in the same cycle while rom_sel=5 -> rom_sel=0, new anchor latched, tick_cnt=0.
REQ-040 Anchor hit_x=1000, x=1023 -> rom_col=23, blood_on asserted; x=0..39 -> blood_on=0 (no wrap).
REQ-041 reset asserted in PLAY with rom_sel=7 -> next cycle busy=0, rom_sel=0, blood_on=0, rgb_out=0.
